uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (legal 5..8).
REQ-002 Parameter STOP_TICKS, default 16, stop-bit length in oversample ticks (16 = 1 bit, 24 = 1.5, 32 = 2).
REQ-003 Parameter PARITY_EN, default 0, 1 inserts a parity bit after the data bits.
REQ-004 Parameter PARITY_ODD, default 0, 0 selects even parity and 1 selects odd; ignored when PARITY_EN = 0.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 tick  input  1  16x baud oversample tick, one clk cycle wide.
REQ-008 tx_start  input  1  request to send din; level-sampled each clk.
REQ-009 din  input  8  data to send; bits above DATA_BITS-1 are ignored.
REQ-010 tx  output  1  serial line, registered, idle high.
REQ-011 busy  output  1  high while a frame is in progress.
REQ-012 tx_done_tick  output  1  one-clk pulse at the end of a frame.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-014 In IDLE, tx_start=1 SHALL latch din into a shift register, clear the tick and bit counters, and enter START on the next clk, regardless of tick.
REQ-015 tx_start while busy=1 SHALL be ignored, with no effect on the frame or on the latched data.
REQ-016 tx SHALL be 0 in START, shift-register bit 0 in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-017 tx SHALL change only on the clk edge on which the state or bit changes, so it has no combinational path from inputs.
REQ-018 A 4-bit tick counter SHALL increment only on clk cycles with tick=1; clk cycles without tick SHALL not advance the frame.
REQ-019 START, each DATA bit and PARITY SHALL each last exactly 16 ticks; the state or bit advances on the tick where the counter equals 15, and the counter wraps to 0.
REQ-020 DATA SHALL send LSB first, shifting right once per bit; after bit DATA_BITS-1 the FSM goes to PARITY if PARITY_EN=1, else to STOP.
REQ-021 The parity bit SHALL be the XOR of the DATA_BITS latched bits, inverted when PARITY_ODD=1.
REQ-022 STOP SHALL last STOP_TICKS ticks, using a stop counter wide enough for 32.
REQ-023 On the final stop tick, the FSM SHALL return to IDLE on the next edge, and on that same edge tx_done_tick=1 for one clk and busy=0.
REQ-024 A tx_start in the cycle where tx_done_tick=1 SHALL be accepted (back-to-back frames), giving exactly STOP_TICKS ticks of stop level between frames.
REQ-025 busy SHALL be 1 from the edge after acceptance until the edge that asserts tx_done_tick.
REQ-026 Frame length SHALL be 16*(1+DATA_BITS+PARITY_EN)+STOP_TICKS ticks, plus 1 clk of acceptance latency.
REQ-027 tick=1 and tx_start=1 in the same IDLE cycle SHALL only accept the request; the tick is not counted.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk, force IDLE, tx=1, busy=0, tx_done_tick=0, and zero all counters and the shift register.
REQ-029 Reset mid-frame SHALL abort the frame with no tx_done_tick, and the line SHALL be high from reset assertion.
REQ-030 After rst_n rises, the first tx_start SHALL be accepted normally on the next clk edge.

Verification
REQ-031 Defaults, tick every clk, din=0x55 -> tx = 0, 1,0,1,0,1,0,1,0 then 1, each held 16 clks; tx_done_tick pulse 161 clks after the accept edge; busy low after.
REQ-032 tick every 4th clk, din=0xA3 -> each bit held 64 clks; a uart_rx instance looped on tx reports dout=0xA3 with rx_done_tick once.
REQ-033 PARITY_EN=1, PARITY_ODD=0, din=0x07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; frame is 176 ticks.
REQ-034 tx_start pulsed mid-frame with din=0xFF while sending 0x12 -> line carries 0x12 only, one tx_done_tick.
REQ-035 rst_n pulled low at data bit 3 -> tx=1, busy=0 asynchronously, no done pulse; a new send of 0x3C after release is correct.
REQ-036 tx_start held high continuously, STOP_TICKS=32 -> contiguous frames with 32-tick stop gaps and one tx_done_tick per frame.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: 16x-oversampled serial framer with optional parity bit
// and a configurable stop length. The line output is fully registered.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_TICKS = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx,
    output logic       busy,
    output logic       tx_done_tick
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [7:0] DATA_MASK  = 8'((16'd1 << DATA_BITS) - 16'd1);
    localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);
    localparam logic [5:0] STOP_END   = 6'(STOP_TICKS);
    localparam logic       HAS_PARITY = (PARITY_EN != 0);
    localparam logic       ODD_BIT    = (PARITY_ODD != 0);

    logic [2:0] state_q, state_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [5:0] stop_cnt_q, stop_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       parity_q, parity_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] din_m;

    assign din_m = din & DATA_MASK;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shreg_d    = shreg_q;
        parity_d   = parity_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A tick in the accepting cycle is deliberately not counted.
                if (tx_start) begin
                    shreg_d    = din_m;
                    parity_d   = (^din_m) ^ ODD_BIT;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        shreg_d = {1'b0, shreg_q[7:1]};
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            state_d   = HAS_PARITY ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // Counter reaches STOP_END on the final stop tick; the frame closes one clk later.
                if (stop_cnt_q == STOP_END) begin
                    stop_cnt_d = '0;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end else if (tick) begin
                    stop_cnt_d = stop_cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            shreg_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx           = tx_q;
    assign busy         = busy_q;
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four parameterisations share one stimulus set.
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       tx_start;
    logic [7:0] din;
    logic       tx0, busy0, done0;
    logic       tx1, busy1, done1;
    logic       tx2, busy2, done2;
    logic       tx3, busy3, done3;

    int checks = 0;
    int errors = 0;
    int tick_div = 1;
    int tick_cnt = 0;
    int dcnt0 = 0;

    uart_tx u0 (.clk(clk), .rst_n(rst_n), .tick(tick), .tx_start(tx_start), .din(din),
                .tx(tx0), .busy(busy0), .tx_done_tick(done0));
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (.clk(clk), .rst_n(rst_n), .tick(tick),
                .tx_start(tx_start), .din(din), .tx(tx1), .busy(busy1), .tx_done_tick(done1));
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (.clk(clk), .rst_n(rst_n), .tick(tick),
                .tx_start(tx_start), .din(din), .tx(tx2), .busy(busy2), .tx_done_tick(done2));
    uart_tx #(.STOP_TICKS(32)) u3 (.clk(clk), .rst_n(rst_n), .tick(tick), .tx_start(tx_start),
                .din(din), .tx(tx3), .busy(busy3), .tx_done_tick(done3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick generator: one-clk pulse every tick_div clocks.
    initial begin
        tick = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tick_cnt = (tick_cnt + 1) % tick_div;
            tick = (tick_cnt == 0);
        end
    end

    always @(posedge clk) begin
        if (done0) dcnt0 <= dcnt0 + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic start_frame(input logic [7:0] d);
        @(negedge clk);
        din = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy0 || busy1 || busy2 || busy3) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy0 || busy1 || busy2 || busy3) begin
            errors++;
            $display("FAIL idle_timeout busy=%b%b%b%b expected 0000", busy0, busy1, busy2, busy3);
        end
    endtask

    // Starts a default-instance frame and records the mid-bit line levels and done pulses.
    task automatic capture_u0(input logic [7:0] d, input int inj_n, input logic [7:0] inj_d,
                              output logic [9:0] obs, output int done_at, output int done_n);
        obs = '0;
        done_at = -1;
        done_n = 0;
        start_frame(d);
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == inj_n) begin
                din = inj_d;
                tx_start = 1'b1;
            end else begin
                tx_start = 1'b0;
            end
            if (n % 16 == 8 && n < 160) obs = {tx0, obs[9:1]};
            if (done0) begin
                done_n++;
                if (done_at < 0) done_at = n;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (tx0 !== 1'b1 || tx3 !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx tx0=%b tx3=%b expected 1 1", tx0, tx3);
        end
        checks++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy busy0=%b busy1=%b expected 0 0", busy0, busy1);
        end
        checks++;
        if (done0 !== 1'b0 || done2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_done done0=%b done2=%b expected 0 0", done0, done2);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset tx=%b busy=%b expected 1 0", tx0, busy0);
        end
    endtask

    task automatic test_basic();
        logic [9:0] obs;
        logic [9:0] exp_f;
        exp_f = {1'b1, 8'h55, 1'b0};
        obs = '0;
        start_frame(8'h55);
        checks++;
        if (busy0 !== 1'b1 || tx0 !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept busy=%b tx=%b expected 1 0", busy0, tx0);
        end
        for (int n = 1; n <= 163; n++) begin
            @(negedge clk);
            if (n % 16 == 8 && n < 160) obs = {tx0, obs[9:1]};
            if (n == 15) begin
                checks++;
                if (tx0 !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_start_end tx=%b expected 0", tx0);
                end
            end
            if (n == 16) begin
                checks++;
                if (tx0 !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_bit0_begin tx=%b expected 1", tx0);
                end
            end
            if (n == 160) begin
                checks++;
                if (done0 !== 1'b0 || busy0 !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_pre_done done=%b busy=%b expected 0 1", done0, busy0);
                end
            end
            if (n == 161) begin
                checks++;
                if (done0 !== 1'b1 || busy0 !== 1'b0 || tx0 !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_done done=%b busy=%b tx=%b expected 1 0 1", done0, busy0, tx0);
                end
            end
            if (n == 162) begin
                checks++;
                if (done0 !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_done_width done=%b expected 0", done0);
                end
            end
        end
        checks++;
        if (obs !== exp_f) begin
            errors++;
            $display("FAIL basic_frame got=%b expected=%b", obs, exp_f);
        end
        wait_idle();
    endtask

    task automatic test_parity();
        start_frame(8'h07);
        for (int n = 1; n <= 178; n++) begin
            @(negedge clk);
            if (n == 136) begin
                checks++;
                if (tx1 !== 1'b0 || tx2 !== 1'b0) begin
                    errors++;
                    $display("FAIL parity_bit7 tx1=%b tx2=%b expected 0 0", tx1, tx2);
                end
            end
            if (n == 152) begin
                checks++;
                if (tx1 !== 1'b1 || tx2 !== 1'b0) begin
                    errors++;
                    $display("FAIL parity_bit even=%b odd=%b expected 1 0", tx1, tx2);
                end
            end
            if (n == 168) begin
                checks++;
                if (tx1 !== 1'b1 || tx2 !== 1'b1) begin
                    errors++;
                    $display("FAIL parity_stop tx1=%b tx2=%b expected 1 1", tx1, tx2);
                end
            end
            if (n == 176) begin
                checks++;
                if (done1 !== 1'b0 || busy1 !== 1'b1 || done3 !== 1'b0) begin
                    errors++;
                    $display("FAIL parity_pre_done done1=%b busy1=%b done3=%b expected 0 1 0", done1, busy1, done3);
                end
            end
            if (n == 177) begin
                checks++;
                if (done1 !== 1'b1 || done2 !== 1'b1 || busy1 !== 1'b0 || done3 !== 1'b1) begin
                    errors++;
                    $display("FAIL parity_done done1=%b done2=%b busy1=%b done3=%b expected 1 1 0 1",
                             done1, done2, busy1, done3);
                end
            end
        end
        wait_idle();
    endtask

    task automatic test_div4();
        int edges[16];
        int ne;
        logic prev;
        logic [9:0] rx_bits;
        int rx_done;
        int d0;
        tick_div = 4;
        repeat (8) @(negedge clk);
        ne = 0;
        rx_bits = '0;
        rx_done = 0;
        d0 = dcnt0;
        start_frame(8'hA3);
        prev = tx0;
        for (int n = 1; n <= 720; n++) begin
            @(negedge clk);
            if (tx0 !== prev && ne < 16) begin
                edges[ne] = n;
                ne++;
            end
            prev = tx0;
            if (n >= 32 && (n - 32) % 64 == 0 && (n - 32) / 64 < 10) begin
                rx_bits = {tx0, rx_bits[9:1]};
                if ((n - 32) / 64 == 9 && rx_bits[0] == 1'b0 && rx_bits[9] == 1'b1) rx_done++;
            end
        end
        checks++;
        if (rx_bits[8:1] !== 8'hA3 || rx_done != 1) begin
            errors++;
            $display("FAIL div4_rx dout=%h rx_done=%0d expected a3 1", rx_bits[8:1], rx_done);
        end
        checks++;
        if (ne < 5) begin
            errors++;
            $display("FAIL div4_edges count=%0d expected at least 5", ne);
        end else begin
            checks++;
            if (edges[0] < 61 || edges[0] > 64) begin
                errors++;
                $display("FAIL div4_start_len got=%0d expected 61..64", edges[0]);
            end
            checks++;
            if (edges[1] - edges[0] != 128 || edges[2] - edges[1] != 192) begin
                errors++;
                $display("FAIL div4_runs got=%0d,%0d expected 128,192", edges[1] - edges[0], edges[2] - edges[1]);
            end
            checks++;
            if (edges[3] - edges[2] != 64 || edges[4] - edges[3] != 64) begin
                errors++;
                $display("FAIL div4_bit_len got=%0d,%0d expected 64,64", edges[3] - edges[2], edges[4] - edges[3]);
            end
        end
        checks++;
        if (dcnt0 - d0 != 1) begin
            errors++;
            $display("FAIL div4_done_count got=%0d expected 1", dcnt0 - d0);
        end
        wait_idle();
        tick_div = 1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        logic [9:0] obs;
        int done_at, done_n;
        capture_u0(8'h12, 40, 8'hFF, obs, done_at, done_n);
        checks++;
        if (obs !== {1'b1, 8'h12, 1'b0}) begin
            errors++;
            $display("FAIL ignore_frame got=%b expected=%b", obs, {1'b1, 8'h12, 1'b0});
        end
        checks++;
        if (done_n != 1 || done_at != 161) begin
            errors++;
            $display("FAIL ignore_done count=%0d at=%0d expected 1 at 161", done_n, done_at);
        end
        checks++;
        if (busy0 !== 1'b0 || tx0 !== 1'b1) begin
            errors++;
            $display("FAIL ignore_idle busy=%b tx=%b expected 0 1", busy0, tx0);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        logic [9:0] obs;
        int done_at, done_n;
        int d0;
        start_frame(8'h00);
        repeat (72) @(negedge clk);
        checks++;
        if (tx0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre tx=%b busy=%b expected 0 1", tx0, busy0);
        end
        d0 = dcnt0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async tx=%b busy=%b done=%b expected 1 0 0", tx0, busy0, done0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        checks++;
        if (dcnt0 != d0 || tx0 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_no_done pulses=%0d tx=%b expected 0 1", dcnt0 - d0, tx0);
        end
        capture_u0(8'h3C, -1, 8'h00, obs, done_at, done_n);
        checks++;
        if (obs !== {1'b1, 8'h3C, 1'b0} || done_at != 161 || done_n != 1) begin
            errors++;
            $display("FAIL rstmid_resend frame=%b done_at=%0d n=%0d expected %b 161 1",
                     obs, done_at, done_n, {1'b1, 8'h3C, 1'b0});
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int dt[4];
        int nd;
        int stop_lows;
        logic [8:0] obs2;
        nd = 0;
        stop_lows = 0;
        obs2 = '0;
        @(negedge clk);
        din = 8'h96;
        tx_start = 1'b1;
        for (int n = 0; n <= 540; n++) begin
            @(negedge clk);
            if (done3 && nd < 4) begin
                dt[nd] = n;
                nd++;
            end
            if (n >= 144 && n <= 177 && tx3 !== 1'b1) stop_lows++;
            if (n >= 178 && n < 178 + 144 && (n - 178) % 16 == 8) obs2 = {tx3, obs2[8:1]};
            if (n == 178) begin
                checks++;
                if (tx3 !== 1'b0 || busy3 !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_restart tx=%b busy=%b expected 0 1", tx3, busy3);
                end
            end
        end
        tx_start = 1'b0;
        checks++;
        if (nd != 3) begin
            errors++;
            $display("FAIL b2b_done_count got=%0d expected 3", nd);
        end else begin
            checks++;
            if (dt[0] != 177 || dt[1] != 355 || dt[2] != 533) begin
                errors++;
                $display("FAIL b2b_done_times got=%0d,%0d,%0d expected 177,355,533", dt[0], dt[1], dt[2]);
            end
        end
        checks++;
        if (stop_lows != 0) begin
            errors++;
            $display("FAIL b2b_stop_gap low_samples=%0d expected 0", stop_lows);
        end
        checks++;
        if (obs2 !== {8'h96, 1'b0}) begin
            errors++;
            $display("FAIL b2b_frame2 got=%b expected=%b", obs2, {8'h96, 1'b0});
        end
        wait_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        tx_start = 1'b0;
        din = 8'h00;
        test_reset();
        test_basic();
        test_parity();
        test_div4();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
